// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped programmable down-counting timer on the data bus.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous, active-high reset
//   ce      in   bus access strobe
//   we      in   write enable, qualified by ce
//   addr    in   [31:0] byte address
//   wtData  in   [31:0] write data
//   rdData  out  [31:0] read data, combinational from the register file
//   irq     out  level interrupt request (EXP & IE), registered
//
// Register window (32 bytes at BASE_ADDR, index = addr[4:2]):
//   0 CTRL {IE,AUTO,EN}, 1 PRESC, 2 LOAD, 3 COUNT (RO), 4 STATUS {EXP} (W1C),
//   5 MISS (only with MMIO_TIMER_MISSCNT_EN defined, else reads 0), 6-7 read 0.
//
// Build option: define MMIO_TIMER_MISSCNT_EN to add the 8-bit saturating
// missed-expiry counter at offset 5.

module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        irq
);

  localparam int unsigned IDX_W = 3;

  localparam logic [IDX_W-1:0] REG_CTRL   = 3'd0;
  localparam logic [IDX_W-1:0] REG_PRESC  = 3'd1;
  localparam logic [IDX_W-1:0] REG_LOAD   = 3'd2;
  localparam logic [IDX_W-1:0] REG_COUNT  = 3'd3;
  localparam logic [IDX_W-1:0] REG_STATUS = 3'd4;
  localparam logic [IDX_W-1:0] REG_MISS   = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
  logic [31:0]             load_q, load_d;
  logic [31:0]             count_q, count_d;
  logic                    exp_q, exp_d;
  logic                    irq_q, irq_d;

  logic                    sel;
  logic [IDX_W-1:0]        idx;
  logic                    wr;
  logic                    ctrl_wr;
  logic                    w1c;
  logic                    expire;
  logic                    unused_addr;

  // Window decode; byte-lane bits are don't-care.
  assign sel         = ce && (addr[31:5] == BASE_ADDR[31:5]);
  assign idx         = addr[4:2];
  assign wr          = sel && we;
  assign ctrl_wr     = wr && (idx == REG_CTRL);
  assign w1c         = wr && (idx == REG_STATUS) && wtData[0];
  assign unused_addr = ^addr[1:0];

`ifdef MMIO_TIMER_MISSCNT_EN
  logic [7:0] miss_q, miss_d;
`endif

  // Next-state: counting, expiry and software writes.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    load_d  = load_q;
    count_d = count_q;
    expire  = 1'b0;

    // A CTRL write on this edge overrides (and discards) any tick.
    if ((state_q == RUN) && !ctrl_wr) begin
      if (pcnt_q != presc_q) begin
        pcnt_d = pcnt_q + 1'b1;
      end else begin
        pcnt_d = '0;
        if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else begin
          expire = 1'b1;
          if (ctrl_q[1]) begin
            count_d = load_q;
          end else begin
            state_d   = DONE;
            ctrl_d[0] = 1'b0;
          end
        end
      end
    end

    if (ctrl_wr) begin
      ctrl_d = wtData[2:0];
      if (wtData[0]) begin
        // Enabling an already running timer does not restart it.
        if (state_q != RUN) begin
          state_d = RUN;
          count_d = load_q;
          pcnt_d  = '0;
        end
      end else begin
        state_d = IDLE;
      end
    end

    if (wr && (idx == REG_PRESC)) presc_d = wtData[PRESCALE_W-1:0];
    if (wr && (idx == REG_LOAD))  load_d  = wtData;

    // Hardware set beats software clear.
    exp_d = expire | (exp_q & ~w1c);
    irq_d = exp_d & ctrl_d[2];
  end

`ifdef MMIO_TIMER_MISSCNT_EN
  // Missed-expiry counter: clear and increment together leave 1.
  always_comb begin
    miss_d = miss_q;
    if (expire && exp_q && (miss_q != 8'hFF)) miss_d = miss_q + 8'd1;
    if (w1c) miss_d = (expire && exp_q) ? 8'd1 : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) miss_q <= '0;
    else     miss_q <= miss_d;
  end
`endif

  // State and register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      irq_q   <= irq_d;
    end
  end

  // Read mux, zero-extended; 0 outside the window.
  always_comb begin
    rdData = 32'd0;
    if (sel) begin
      unique case (idx)
        REG_CTRL:   rdData = 32'(ctrl_q);
        REG_PRESC:  rdData = 32'(presc_q);
        REG_LOAD:   rdData = load_q;
        REG_COUNT:  rdData = count_q;
        REG_STATUS: rdData = 32'(exp_q);
`ifdef MMIO_TIMER_MISSCNT_EN
        REG_MISS:   rdData = 32'(miss_q);
`else
        REG_MISS:   rdData = 32'd0;
`endif
        default:    rdData = 32'd0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed plus randomized bench for mmio_timer with a
// transaction-level reference model of the register file and timer.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_8000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_PRESC  = BASE + 32'h04;
  localparam logic [31:0] A_LOAD   = BASE + 32'h08;
  localparam logic [31:0] A_COUNT  = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;
  localparam logic [31:0] A_MISS   = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wtData;
  logic [31:0] rdData;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_rd;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr),
    .wtData(wtData), .rdData(rdData), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: timer is either running or stopped; stopped covers idle and done.
  bit [2:0]  m_ctrl;
  bit [15:0] m_presc, m_pcnt;
  bit [31:0] m_load, m_count;
  bit        m_exp, m_run, m_irq;
  int        m_miss;

  task automatic model_reset();
    m_ctrl = 0; m_presc = 0; m_pcnt = 0; m_load = 0; m_count = 0;
    m_exp = 0; m_run = 0; m_irq = 0; m_miss = 0;
  endtask

  function automatic logic [31:0] model_read(input logic c, input logic [31:0] a);
    if (!c || (a[31:5] != BASE[31:5])) return 32'd0;
    case (a[4:2])
      3'd0: return {29'd0, m_ctrl};
      3'd1: return {16'd0, m_presc};
      3'd2: return m_load;
      3'd3: return m_count;
      3'd4: return {31'd0, m_exp};
`ifdef MMIO_TIMER_MISSCNT_EN
      3'd5: return 32'(m_miss);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    bit wr, ctrl_w, clr, expired;
    bit [2:0]  n_ctrl;
    bit [15:0] n_pcnt;
    bit [31:0] n_count;
    bit        n_run;
    wr      = c && w && (a[31:5] == BASE[31:5]);
    ctrl_w  = wr && a[4:2] == 3'd0;
    clr     = wr && a[4:2] == 3'd4 && d[0];
    expired = 0;
    n_ctrl = m_ctrl; n_pcnt = m_pcnt; n_count = m_count; n_run = m_run;
    if (m_run && !ctrl_w) begin
      if (m_pcnt != m_presc) n_pcnt = m_pcnt + 1;
      else begin
        n_pcnt = 0;
        if (m_count != 0) n_count = m_count - 1;
        else begin
          expired = 1;
          if (m_ctrl[1]) n_count = m_load;
          else begin n_run = 0; n_ctrl[0] = 0; end
        end
      end
    end
    if (ctrl_w) begin
      n_ctrl = d[2:0];
      if (!d[0]) n_run = 0;
      else if (!m_run) begin n_run = 1; n_count = m_load; n_pcnt = 0; end
    end
    if (wr && a[4:2] == 3'd1) m_presc = d[15:0];
    if (wr && a[4:2] == 3'd2) m_load = d;
    if (clr) m_miss = (expired && m_exp) ? 1 : 0;
    else if (expired && m_exp && m_miss < 255) m_miss = m_miss + 1;
    m_exp   = expired || (m_exp && !clr);
    m_ctrl  = n_ctrl; m_pcnt = n_pcnt; m_count = n_count; m_run = n_run;
    m_irq   = m_exp && m_ctrl[2];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One bus cycle: drive after negedge, check read data, clock, check irq.
  task automatic cyc(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    ce = c; we = w; addr = a; wtData = d;
    #1;
    last_rd = rdData;
    chk("rdData", rdData, model_read(c, a));
    @(posedge clk);
    model_edge(c, w, a, d);
    @(negedge clk);
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    cyc(1'b1, 1'b0, a, 32'd0);
  endtask

  initial begin
    int k;
    logic [31:0] a, d;
    int r;
    rst = 1'b1; ce = 1'b1; we = 1'b0; addr = A_CTRL; wtData = '0;
    model_reset();
    #12;
    chk("reset_rd", rdData, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset mid-count.
    wr_reg(A_PRESC, 32'd3);
    wr_reg(A_LOAD, 32'd100);
    wr_reg(A_CTRL, 32'h5);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    ce = 1'b1; we = 1'b0; addr = A_COUNT;
    #1; chk("pre_rst_count_nonzero", {31'd0, rdData != 0}, 32'd1);
    #1; rst = 1'b1;
    #1;
    chk("rst_async_count", rdData, 32'd0);
    chk("rst_async_irq", {31'd0, irq}, 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) rd_reg(A_COUNT);
    chk("post_rst_count", last_rd, 32'd0);
    rd_reg(A_CTRL);
    chk("post_rst_ctrl", last_rd, 32'd0);

    // One-shot latency.
    wr_reg(A_PRESC, 32'd1);
    wr_reg(A_LOAD, 32'd2);
    wr_reg(A_CTRL, 32'h5);
    k = 21;
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 32'd0);
      if (irq === 1'b1) begin k = i; break; end
    end
    chk("oneshot_latency", 32'(k), 32'd6);
    rd_reg(A_CTRL);   chk("oneshot_ctrl", last_rd, 32'h4);
    rd_reg(A_COUNT);  chk("oneshot_count", last_rd, 32'd0);
    rd_reg(A_STATUS); chk("oneshot_exp", last_rd, 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    rd_reg(A_COUNT);  chk("done_holds", last_rd, 32'd0);

    // Auto-reload with IE=0.
    wr_reg(A_STATUS, 32'd1);
    wr_reg(A_PRESC, 32'd0);
    wr_reg(A_LOAD, 32'd3);
    wr_reg(A_CTRL, 32'h3);
    for (int j = 0; j < 12; j++) begin
      rd_reg(A_COUNT);
      chk("auto_count", last_rd, 32'(3 - (j % 4)));
      chk("auto_irq_masked", {31'd0, irq}, 32'd0);
    end

    // W1C versus hardware set.
    wr_reg(A_LOAD, 32'd0);
    wr_reg(A_CTRL, 32'h3);
    for (int i = 0; i < 6; i++) wr_reg(A_STATUS, 32'd1);
    rd_reg(A_STATUS); chk("w1c_set_wins", last_rd, 32'd1);
    wr_reg(A_CTRL, 32'h0);
    wr_reg(A_STATUS, 32'd1);
    rd_reg(A_STATUS); chk("w1c_clear", last_rd, 32'd0);
    chk("w1c_irq", {31'd0, irq}, 32'd0);

    // Address decode.
    wr_reg(A_LOAD, 32'h1234);
    wr_reg(BASE + 32'h28, 32'hDEAD);
    cyc(1'b1, 1'b1, BASE - 32'd4, 32'hBEEF);
    cyc(1'b1, 1'b0, BASE + 32'h28, 32'd0); chk("oob_hi_rd", last_rd, 32'd0);
    cyc(1'b1, 1'b0, BASE - 32'd4, 32'd0);  chk("oob_lo_rd", last_rd, 32'd0);
    cyc(1'b0, 1'b1, A_LOAD, 32'h7777);
    rd_reg(A_LOAD);  chk("decode_load", last_rd, 32'h1234);
    wr_reg(A_COUNT, 32'h55);
    rd_reg(A_COUNT); chk("count_ro", last_rd, 32'd0);
    cyc(1'b0, 1'b0, A_CTRL, 32'd0); chk("no_ce_rd", last_rd, 32'd0);

    // Missed-expiry counter.
    wr_reg(A_LOAD, 32'd0);
    wr_reg(A_PRESC, 32'd0);
    wr_reg(A_CTRL, 32'h3);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
    rd_reg(A_MISS);
`ifdef MMIO_TIMER_MISSCNT_EN
    chk("miss_sat", last_rd, 32'hFF);
    wr_reg(A_STATUS, 32'd1);
    rd_reg(A_MISS);
    chk("miss_clear_collide", last_rd, 32'd1);
`else
    chk("miss_absent", last_rd, 32'd0);
`endif
    wr_reg(A_CTRL, 32'h0);
    wr_reg(A_STATUS, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      a = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'd0};
      if ($urandom_range(0, 19) == 0) a = a + 32'h40;
      if (r < 25) begin
        cyc(1'b0, 1'($urandom), a, $urandom);
      end else if (r < 70) begin
        cyc(1'b1, 1'b0, a, $urandom);
      end else begin
        case (a[4:2])
          3'd0: d = ($urandom_range(0, 3) == 0) ? 32'(3'($urandom)) : {$urandom, 3'b000} | 32'h1;
          3'd1: d = $urandom & 32'hFFFF_0003;
          3'd2: d = 32'($urandom_range(0, 6));
          default: d = $urandom;
        endcase
        if (a[4:2] == 3'd0 && $urandom_range(0, 3) != 0) cyc(1'b1, 1'b0, a, d);
        else cyc(1'b1, 1'b1, a, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
